robots_ps2_rx: RTL



---
 rtl/robots_ps2_rx_pkg.sv | 22 ++
 rtl/robots_ps2_rx_if.sv | 19 +
 rtl/robots_ps2_rx_sync_filter.sv | 37 +++
 rtl/robots_ps2_rx.sv | 111 +++++++++++
 4 files changed

// File: rtl/robots_ps2_rx_pkg.sv
// Shared definitions for the robots PS/2 receive path and the downstream scan-code decoder.
package robots_ps2_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam int PS2_FRAME_BITS = 11;

  // Scan-code prefixes consumed by the keyboard-command decoder.
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/robots_ps2_rx_if.sv
// Byte stream and error pulses from the PS/2 receiver to its consumer.
interface robots_ps2_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err_parity;
  logic       err_frame;
  logic       err_overrun;

  modport master (
    output rx_data, rx_valid, err_parity, err_frame, err_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, err_parity, err_frame, err_overrun,
    output rx_ready
  );
endinterface

// File: rtl/robots_ps2_rx_sync_filter.sv
// Two-flop synchroniser followed by a level filter that ignores pulses shorter than FILT_LEN cycles.
module robots_ps2_rx_sync_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

  logic       sync1, sync2;
  logic [7:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      dout  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/robots_ps2_rx.sv
// PS/2 port A receiver: conditions the pins, deframes 11-bit frames, and buffers one byte.
module robots_ps2_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk_i,
  input  logic           ps2_dat_i,
  robots_ps2_rx_if.master rx
);
  import robots_ps2_rx_pkg::*;

  // Compared against the pre-increment count so the abort lands on the edge the count reaches TIMEOUT_CYC-1.
  localparam logic [19:0] TMO_FIRE = 20'(TIMEOUT_CYC - 2);

  logic       clk_f, dat_f, clk_f_q, fall;
  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_q;
  logic [19:0] tmo;
  logic       frame_good, parity_bad, frame_bad;
  logic [7:0] data_q;
  logic       valid_q, perr_q, ferr_q, oerr_q;

  robots_ps2_rx_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .din(ps2_clk_i), .dout(clk_f)
  );

  robots_ps2_rx_sync_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk(clk), .rst(rst), .din(ps2_dat_i), .dout(dat_f)
  );

  assign fall = clk_f_q & ~clk_f;

  // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    frame_good = 1'b0;
    parity_bad = 1'b0;
    frame_bad  = 1'b0;
    if (fall) begin
      unique case (state_q)
        RX_IDLE:   if (!dat_f) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          state_d = RX_IDLE;
          if (!dat_f)                            frame_bad  = 1'b1;
          else if (!odd_parity_ok(shift, par_q)) parity_bad = 1'b1;
          else                                   frame_good = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo == TMO_FIRE) begin
      state_d   = RX_IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      clk_f_q <= 1'b1;
      bit_cnt <= '0;
      shift   <= '0;
      par_q   <= 1'b0;
      tmo     <= '0;
    end else begin
      state_q <= state_d;
      clk_f_q <= clk_f;
      if (fall && state_q == RX_IDLE) bit_cnt <= '0;
      if (fall && state_q == RX_DATA) begin
        shift   <= {dat_f, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state_q == RX_PARITY) par_q <= dat_f;
      if (fall || state_q == RX_IDLE || state_d == RX_IDLE) tmo <= '0;
      else                                                  tmo <= tmo + 20'd1;
    end
  end

  // A simultaneous consume frees the buffer in the same cycle the new byte arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      perr_q <= parity_bad;
      ferr_q <= frame_bad;
      oerr_q <= frame_good && valid_q && !rx.rx_ready;
      if (frame_good && (!valid_q || rx.rx_ready)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.err_parity  = perr_q;
  assign rx.err_frame   = ferr_q;
  assign rx.err_overrun = oerr_q;

endmodule
